// File: rtl/caravel_clk_switch_ctrl_pkg.sv
// Shared definitions for the clock-switch sequencer: state encodings (also used by
// housekeeping status readback) and default timing parameters.
package caravel_clk_switch_ctrl_pkg;

    localparam int unsigned LOCK_TIMEOUT_DEF  = 1000;
    localparam int unsigned SWITCH_CYCLES_DEF = 8;
    localparam int unsigned CNT_W_DEF         = 12;

    typedef logic [2:0] state_t;

    localparam state_t ST_EXT_RUN    = 3'd0;
    localparam state_t ST_PLL_START  = 3'd1;
    localparam state_t ST_PLL_SWITCH = 3'd2;
    localparam state_t ST_PLL_RUN    = 3'd3;
    localparam state_t ST_PLL_EXIT   = 3'd4;
    localparam state_t ST_PLL_STOP   = 3'd5;
    localparam state_t ST_ERROR      = 3'd6;

    // Settled states are the ones in which the sequencer is not mid-transition.
    function automatic logic state_is_settled(input state_t s);
        return (s == ST_EXT_RUN) || (s == ST_PLL_RUN) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/caravel_sync2.sv
// Generic two-flop synchronizer for bringing asynchronous flags into a clock domain.
module caravel_sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/caravel_clk_switch_ctrl.sv
// Sequencer in front of the core clocking block: orders PLL enable, clock select and
// divider changes so dividers only move while running from the external clock.
module caravel_clk_switch_ctrl
    import caravel_clk_switch_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
    parameter int unsigned SWITCH_CYCLES = SWITCH_CYCLES_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_pll_en,
    input  logic [2:0] cfg_sel,
    input  logic [2:0] cfg_sel2,
    input  logic       cfg_apply,
    input  logic       err_clr,
    input  logic       pll_lock_async,
    output logic       pll_ena,
    output logic       ext_clk_sel,
    output logic [2:0] sel,
    output logic [2:0] sel2,
    output logic       busy,
    output logic       lock_err,
    output logic [2:0] state_o
);

    logic             w_lock_s;
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_sh_pll_en;
    logic [2:0]       r_sh_sel;
    logic [2:0]       r_sh_sel2;
    logic [2:0]       r_sel;
    logic [2:0]       r_sel2;
    logic             r_pll_ena;
    logic             r_ext_clk_sel;
    logic             r_busy;
    logic             r_lock_err;
    logic             w_load_sel;
    logic             w_accept;
    logic             w_timeout;
    logic             w_switch_done;

    caravel_sync2 #(.W(1)) u_lock_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (pll_lock_async),
        .o_q     (w_lock_s)
    );

    assign w_timeout     = (r_cnt == CNT_W'(LOCK_TIMEOUT - 1));
    assign w_switch_done = (r_cnt == CNT_W'(SWITCH_CYCLES - 1));

    // A request arriving together with lock loss in PLL_RUN is dropped.
    assign w_accept = cfg_apply &&
                      ((r_state == ST_EXT_RUN) || ((r_state == ST_PLL_RUN) && w_lock_s));

    always_comb begin
        w_next     = r_state;
        w_load_sel = 1'b0;
        case (r_state)
            ST_EXT_RUN: begin
                if (r_pending) begin
                    w_load_sel = 1'b1;
                    if (r_sh_pll_en) w_next = ST_PLL_START;
                end
            end
            ST_PLL_START: begin
                if (w_lock_s)       w_next = ST_PLL_SWITCH;
                else if (w_timeout) w_next = ST_ERROR;
            end
            ST_PLL_SWITCH: begin
                if (!w_lock_s)          w_next = ST_ERROR;
                else if (w_switch_done) w_next = ST_PLL_RUN;
            end
            ST_PLL_RUN: begin
                if (!w_lock_s)      w_next = ST_ERROR;
                else if (r_pending) w_next = ST_PLL_EXIT;
            end
            ST_PLL_EXIT: begin
                if (w_switch_done) begin
                    w_load_sel = 1'b1;
                    w_next     = r_sh_pll_en ? ST_PLL_SWITCH : ST_PLL_STOP;
                end
            end
            ST_PLL_STOP: begin
                if (w_switch_done) w_next = ST_EXT_RUN;
            end
            ST_ERROR: begin
                if (err_clr) w_next = ST_EXT_RUN;
            end
            default: w_next = ST_EXT_RUN;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_EXT_RUN;
            r_cnt         <= '0;
            r_pending     <= 1'b0;
            r_sh_pll_en   <= 1'b0;
            r_sh_sel      <= '0;
            r_sh_sel2     <= '0;
            r_sel         <= '0;
            r_sel2        <= '0;
            r_pll_ena     <= 1'b0;
            r_ext_clk_sel <= 1'b1;
            r_busy        <= 1'b0;
            r_lock_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);

            if (w_next == ST_ERROR)  r_pending <= 1'b0;
            else if (w_accept)       r_pending <= 1'b1;
            else if (w_load_sel)     r_pending <= 1'b0;

            if (w_accept) begin
                r_sh_pll_en <= cfg_pll_en;
                r_sh_sel    <= cfg_sel;
                r_sh_sel2   <= cfg_sel2;
            end

            if (w_load_sel) begin
                r_sel  <= r_sh_sel;
                r_sel2 <= r_sh_sel2;
            end

            r_pll_ena     <= (w_next == ST_PLL_START) || (w_next == ST_PLL_SWITCH) ||
                             (w_next == ST_PLL_RUN)   || (w_next == ST_PLL_EXIT);
            r_ext_clk_sel <= !((w_next == ST_PLL_SWITCH) || (w_next == ST_PLL_RUN));
            r_busy        <= !state_is_settled(w_next);
            r_lock_err    <= (w_next == ST_ERROR);
        end
    end

    assign pll_ena     = r_pll_ena;
    assign ext_clk_sel = r_ext_clk_sel;
    assign sel         = r_sel;
    assign sel2        = r_sel2;
    assign busy        = r_busy;
    assign lock_err    = r_lock_err;
    assign state_o     = r_state;

endmodule

// File: tb/tb_caravel_clk_switch_ctrl.sv
// Directed self-checking bench for the clock-switch sequencer.
module tb_caravel_clk_switch_ctrl;

    logic       clk;
    logic       reset;
    logic       cfgPllEn;
    logic [2:0] cfgSel;
    logic [2:0] cfgSel2;
    logic       cfgApply;
    logic       errClr;
    logic       pllLockAsync;
    logic       pllEna;
    logic       extClkSel;
    logic [2:0] sel;
    logic [2:0] sel2;
    logic       busy;
    logic       lockErr;
    logic [2:0] stateO;

    int errors = 0;
    int checks = 0;

    logic       prevValid = 1'b0;
    logic       prevExt;
    logic [2:0] prevSel;
    logic [2:0] prevSel2;

    caravel_clk_switch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_pll_en     (cfgPllEn),
        .cfg_sel        (cfgSel),
        .cfg_sel2       (cfgSel2),
        .cfg_apply      (cfgApply),
        .err_clr        (errClr),
        .pll_lock_async (pllLockAsync),
        .pll_ena        (pllEna),
        .ext_clk_sel    (extClkSel),
        .sel            (sel),
        .sel2           (sel2),
        .busy           (busy),
        .lock_err       (lockErr),
        .state_o        (stateO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [2:0] s, input logic [2:0] s2);
        cfgPllEn = en;
        cfgSel   = s;
        cfgSel2  = s2;
        cfgApply = 1'b1;
        step(1);
        cfgApply = 1'b0;
    endtask

    // Dividers may only move while the previous sample showed the external clock selected.
    always @(negedge clk) begin
        if (!reset && prevValid && ((sel !== prevSel) || (sel2 !== prevSel2)))
            checkOutput("selOnlyWhileExt", prevExt, 1);
        prevValid <= !reset;
        prevExt   <= extClkSel;
        prevSel   <= sel;
        prevSel2  <= sel2;
    end

    initial begin
        reset = 1'b1; cfgPllEn = 1'b0; cfgSel = '0; cfgSel2 = '0;
        cfgApply = 1'b0; errClr = 1'b0; pllLockAsync = 1'b0;
        $display("[TB] reset");
        step(3);
        reset = 1'b0;
        checkOutput("rstPllEna", pllEna, 0);
        checkOutput("rstExtSel", extClkSel, 1);
        checkOutput("rstSel", sel, 0);
        checkOutput("rstSel2", sel2, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstLockErr", lockErr, 0);
        checkOutput("rstState", stateO, 0);
        step(2);
        checkOutput("idleState", stateO, 0);

        $display("[TB] PLL bring-up");
        applyStimulus(1'b1, 3'd2, 3'd3);
        step(1);
        checkOutput("startState", stateO, 1);
        checkOutput("startSel", sel, 2);
        checkOutput("startSel2", sel2, 3);
        checkOutput("startExt", extClkSel, 1);
        checkOutput("startPllEna", pllEna, 1);
        checkOutput("startBusy", busy, 1);
        step(19);
        pllLockAsync = 1'b1;
        step(2);
        checkOutput("extBeforeSync", extClkSel, 1);
        step(1);
        checkOutput("extFall", extClkSel, 0);
        checkOutput("switchState", stateO, 2);
        step(7);
        checkOutput("switchHold", stateO, 2);
        step(1);
        checkOutput("runState", stateO, 3);
        checkOutput("runBusy", busy, 0);
        checkOutput("runPllEna", pllEna, 1);

        $display("[TB] divider change in PLL_RUN");
        applyStimulus(1'b1, 3'd5, 3'd3);
        step(1);
        checkOutput("exitState", stateO, 4);
        checkOutput("exitExt", extClkSel, 1);
        checkOutput("exitSelOld", sel, 2);
        for (int i = 0; i < 7; i++) begin
            step(1);
            checkOutput("exitHoldSel", sel, 2);
            checkOutput("exitHoldExt", extClkSel, 1);
        end
        step(1);
        checkOutput("exitSelNew", sel, 5);
        checkOutput("exitExtLow", extClkSel, 0);
        checkOutput("reSwitchState", stateO, 2);
        step(8);
        checkOutput("reRunState", stateO, 3);

        $display("[TB] return to external clock");
        applyStimulus(1'b0, 3'd1, 3'd1);
        step(1);
        checkOutput("exit2State", stateO, 4);
        step(8);
        checkOutput("stopState", stateO, 5);
        checkOutput("stopPllEna", pllEna, 0);
        checkOutput("stopExt", extClkSel, 1);
        checkOutput("stopSel", sel, 1);
        step(8);
        checkOutput("extRunState", stateO, 0);
        checkOutput("extRunBusy", busy, 0);
        pllLockAsync = 1'b0;
        step(3);

        $display("[TB] lock timeout");
        applyStimulus(1'b1, 3'd4, 3'd4);
        step(1);
        checkOutput("toStartState", stateO, 1);
        checkOutput("toStartSel", sel, 4);
        cfgPllEn = 1'b0; cfgSel = 3'd7; cfgSel2 = 3'd7; cfgApply = 1'b1;
        step(1);
        cfgApply = 1'b0;
        step(998);
        checkOutput("toStillStart", stateO, 1);
        checkOutput("toNoErrYet", lockErr, 0);
        checkOutput("toPllEnaYet", pllEna, 1);
        errClr = 1'b1;
        step(1);
        errClr = 1'b0;
        checkOutput("toErrState", stateO, 6);
        checkOutput("toLockErr", lockErr, 1);
        checkOutput("toPllEnaOff", pllEna, 0);
        checkOutput("toExt", extClkSel, 1);
        checkOutput("toBusy", busy, 0);
        step(5);
        checkOutput("toSticky", lockErr, 1);
        checkOutput("toStickyState", stateO, 6);
        errClr = 1'b1;
        step(1);
        errClr = 1'b0;
        checkOutput("clrState", stateO, 0);
        checkOutput("clrLockErr", lockErr, 0);
        step(3);
        checkOutput("droppedSel", sel, 4);
        checkOutput("droppedSel2", sel2, 4);
        checkOutput("droppedState", stateO, 0);

        $display("[TB] lock loss in PLL_RUN");
        applyStimulus(1'b1, 3'd6, 3'd6);
        pllLockAsync = 1'b1;
        step(3);
        checkOutput("llSwitchState", stateO, 2);
        step(8);
        checkOutput("llRunState", stateO, 3);
        checkOutput("llRunSel", sel, 6);
        pllLockAsync = 1'b0;
        step(2);
        checkOutput("llStillRun", stateO, 3);
        checkOutput("llStillPll", extClkSel, 0);
        cfgPllEn = 1'b0; cfgSel = 3'd2; cfgSel2 = 3'd2; cfgApply = 1'b1;
        step(1);
        cfgApply = 1'b0;
        checkOutput("llErrState", stateO, 6);
        checkOutput("llExt", extClkSel, 1);
        checkOutput("llLockErr", lockErr, 1);
        errClr = 1'b1;
        step(1);
        errClr = 1'b0;
        checkOutput("llClrState", stateO, 0);
        step(3);
        checkOutput("llDroppedSel", sel, 6);
        checkOutput("llDroppedState", stateO, 0);

        $display("[TB] reset during PLL_EXIT");
        applyStimulus(1'b1, 3'd3, 3'd3);
        pllLockAsync = 1'b1;
        step(11);
        checkOutput("rxRunState", stateO, 3);
        checkOutput("rxRunSel", sel, 3);
        applyStimulus(1'b1, 3'd1, 3'd1);
        step(3);
        checkOutput("rxExitState", stateO, 4);
        reset = 1'b1;
        step(1);
        checkOutput("rxPllEna", pllEna, 0);
        checkOutput("rxExt", extClkSel, 1);
        checkOutput("rxSel", sel, 0);
        checkOutput("rxSel2", sel2, 0);
        checkOutput("rxBusy", busy, 0);
        checkOutput("rxLockErr", lockErr, 0);
        checkOutput("rxState", stateO, 0);
        reset = 1'b0;
        pllLockAsync = 1'b0;
        step(2);
        checkOutput("rxIdleState", stateO, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
